// File: rtl/can_pkg.sv
// ----------------------------------------------------------------------------
// can_pkg
// Definitions shared by the CAN TX arbiter and the CAN top.
//   CAN_DW      : tx_data width of the CAN top
//   arb_state_t : arbiter FSM states
//   idx_w(n)    : index width for n requesters, max(1, $clog2(n))
// ----------------------------------------------------------------------------
package can_pkg;

    localparam int CAN_DW = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/can_arb_pick.sv
// ----------------------------------------------------------------------------
// can_arb_pick
// Combinational rotate-and-find-first. Returns the first set request bit at
// or after i_start, wrapping modulo NREQ. With i_fixed set the search starts
// at index 0 (lowest index wins).
// Ports:
//   i_req   : request vector
//   i_start : search start index (ignored when i_fixed)
//   i_fixed : fixed-priority select
//   o_any   : at least one request set
//   o_idx   : index of the chosen request (0 when none)
// ----------------------------------------------------------------------------
module can_arb_pick
    import can_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_start,
    input  logic            i_fixed,
    output logic            o_any,
    output logic [IW-1:0]   o_idx
);

    int          w_base;
    int          w_pos;
    logic [IW-1:0] w_pos_idx;

    always_comb begin
        o_any     = 1'b0;
        o_idx     = '0;
        w_base    = i_fixed ? 0 : int'(i_start);
        w_pos     = 0;
        w_pos_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Wrap without a divider: base < NREQ and k < NREQ.
            w_pos = w_base + k;
            if (w_pos >= NREQ) w_pos = w_pos - NREQ;
            w_pos_idx = IW'(w_pos);
            if (!o_any && i_req[w_pos_idx]) begin
                o_any = 1'b1;
                o_idx = w_pos_idx;
            end
        end
    end

endmodule

// File: rtl/can_tx_arbiter.sv
// ----------------------------------------------------------------------------
// can_tx_arbiter
// Shares the CAN controller's TX-buffer push port between NREQ requesters.
// A burst is granted (round-robin by default) and held until the grantee
// hands over a word with req_last or the burst reaches MAX_BURST words. One
// registered output stage feeds tx_valid/tx_data.
//
// Optional build macro:
//   CAN_TX_ARB_FIXED_PRIO_EN : lowest-index requester always wins; the
//                              round-robin pointer is held at 0.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester word valid
//   req_last   : per-requester last word of burst
//   req_data   : requester i at bits [i*DW +: DW]
//   req_ready  : per-requester accept (only the grantee, combinational)
//   tx_valid   : output word valid (to CAN top)
//   tx_ready   : CAN TX FIFO not full
//   tx_data    : output word
//   busy       : a grant is held
//   grant_id   : current or last grantee
// ----------------------------------------------------------------------------
module can_tx_arbiter
    import can_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = CAN_DW,
    parameter int MAX_BURST = 8,
    localparam int IW       = idx_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_last,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [DW-1:0]        tx_data,
    output logic                 busy,
    output logic [IW-1:0]        grant_id
);

    // Count value at which the handshake in flight is the final allowed word.
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

`ifdef CAN_TX_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   r_rr_ptr;
    logic [7:0]      r_burst_cnt;
    logic            r_tx_valid;
    logic [DW-1:0]   r_tx_data;

    logic            w_pick_any;
    logic [IW-1:0]   w_pick_idx;
    logic            w_out_rdy;
    logic            w_hs;
    logic            w_rel;
    logic [DW-1:0]   w_sel_data;
    logic [IW-1:0]   w_ptr_nxt;

    can_arb_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .i_req   (req_valid),
        .i_start (r_rr_ptr),
        .i_fixed (FIXED_PRIO),
        .o_any   (w_pick_any),
        .o_idx   (w_pick_idx)
    );

    // The output stage can take a word when empty or draining this cycle.
    assign w_out_rdy  = ~r_tx_valid | tx_ready;
    assign w_sel_data = req_data[int'(r_grant_id)*DW +: DW];
    assign w_ptr_nxt  = (r_grant_id == IW'(NREQ - 1)) ? '0 : r_grant_id + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_hs        = 1'b0;
        w_rel       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) w_state_nxt = GRANT;
            end
            GRANT: begin
                req_ready[r_grant_id] = w_out_rdy;
                w_hs  = req_valid[r_grant_id] & w_out_rdy;
                w_rel = w_hs & (req_last[r_grant_id] | (r_burst_cnt == BURST_LAST));
                if (w_rel) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            if (r_state == IDLE && w_pick_any) begin
                r_grant_id  <= w_pick_idx;
                r_burst_cnt <= '0;
            end
            if (w_hs) r_burst_cnt <= r_burst_cnt + 8'd1;
            if (w_rel) r_rr_ptr <= FIXED_PRIO ? '0 : w_ptr_nxt;

            // Load wins over drain, so back-to-back words keep tx_valid high.
            if (w_hs) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= w_sel_data;
            end else if (tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state == GRANT);
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_can_tx_arbiter.sv
module tb_can_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int MB   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_last;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                tx_valid;
    logic                tx_ready;
    logic [DW-1:0]       tx_data;
    logic                busy;
    logic [1:0]          grant_id;

    always #5 clk = ~clk;

    can_tx_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester-side word queues: {last, data}
    logic [DW:0]    rq [NREQ][$];
    // Model outputs: expected tx word order and grant order
    logic [DW-1:0]  exp_w [$];
    int             exp_g [$];
    int             m_ptr = 0;
    // Observation logs
    int             txc_log [$];
    logic [DW-1:0]  txd_log [$];
    int             gnt_log [$];
    int             lit [$];

    bit             chk_en = 1'b0;
    int             stall_from = -1;
    int             stall_to   = -1;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Burst-level model: serve whole bursts in arbitration order.
    task automatic build_model();
        logic [DW:0] mq [NREQ][$];
        int g, n, st;
        bit last;
        for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
        forever begin
            g = -1;
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
            st = 0;
`else
            st = m_ptr;
`endif
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && mq[(st + k) % NREQ].size() > 0) g = (st + k) % NREQ;
            if (g < 0) break;
            exp_g.push_back(g);
            n = 0;
            do begin
                last = mq[g][0][DW];
                exp_w.push_back(mq[g][0][DW-1:0]);
                void'(mq[g].pop_front());
                n++;
            end while (!last && n < MB && mq[g].size() > 0);
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = rq[i].size() > 0;
            if (rq[i].size() > 0) begin
                req_last[i]          = rq[i][0][DW];
                req_data[i*DW +: DW] = rq[i][0][DW-1:0];
            end else begin
                req_last[i]          = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
        tx_ready = !(cyc >= stall_from && cyc < stall_to);
    endtask

    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (hs[i]) void'(rq[i].pop_front());
        drive();
    endtask

    task automatic push_burst(input int r, input int n, input logic [DW-1:0] base, input bit last_end);
        for (int k = 0; k < n; k++)
            rq[r].push_back({(last_end && k == n - 1), base + DW'(k)});
    endtask

    function automatic bit pending();
        bit p = exp_w.size() > 0 || exp_g.size() > 0;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input int maxc);
        int n = 0;
        while ((pending() || busy || tx_valid) && n < maxc) begin
            step();
            n++;
        end
        chk(n < maxc, "drain_timeout", n, maxc);
        step();
    endtask

    task automatic clear_logs();
        txc_log.delete();
        txd_log.delete();
        gnt_log.delete();
    endtask

    task automatic cmp_gnt(input string nm);
        chk(gnt_log.size() == lit.size(), {nm, "_len"}, gnt_log.size(), lit.size());
        for (int j = 0; j < lit.size() && j < gnt_log.size(); j++)
            chk(gnt_log[j] == lit[j], nm, gnt_log[j], lit[j]);
    endtask

    // Per-cycle compare against the model and the handshake rules
    logic [NREQ-1:0] rr_e;
    logic            p_busy = 1'b0;
    logic            p_stall = 1'b0;
    logic [DW-1:0]   p_data = '0;
    assign rr_e = (busy && (!tx_valid || tx_ready)) ? (NREQ'(1) << grant_id) : '0;

    always @(negedge clk) begin
        if (!chk_en) begin
            p_busy  <= 1'b0;
            p_stall <= 1'b0;
        end else begin
            chk(req_ready == rr_e, "req_ready", req_ready, rr_e);
            if (p_stall) chk(tx_valid && tx_data == p_data, "tx_hold", tx_data, p_data);
            if (busy && !p_busy) begin
                if (exp_g.size() == 0) chk(1'b0, "grant_unexpected", grant_id, 0);
                else begin
                    chk(int'(grant_id) == exp_g[0], "grant_id", grant_id, exp_g[0]);
                    void'(exp_g.pop_front());
                end
                gnt_log.push_back(int'(grant_id));
            end
            if (tx_valid && tx_ready) begin
                if (exp_w.size() == 0) chk(1'b0, "tx_unexpected", tx_data, 0);
                else begin
                    chk(tx_data == exp_w[0], "tx_data", tx_data, exp_w[0]);
                    void'(exp_w.pop_front());
                end
                txc_log.push_back(cyc);
                txd_log.push_back(tx_data);
            end
            p_busy  <= busy;
            p_stall <= tx_valid && !tx_ready;
            p_data  <= tx_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1;
        drive();
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk(tx_valid == 1'b0, "rst_tx_valid", tx_valid, 0);
        chk(tx_data == '0, "rst_tx_data", tx_data, 0);
        chk(req_ready == '0, "rst_req_ready", req_ready, 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
        chk(grant_id == '0, "rst_grant_id", grant_id, 0);
        chk_en = 1'b1;
        step();

        // 1: requester 2, burst A0,A1,A2
        clear_logs();
        push_burst(2, 3, 32'hA0, 1'b1);
        build_model();
        drive();
        k = cyc;
        step(); #1;
        chk(busy == 1'b1, "t1_busy_n1", busy, 1);
        chk(req_ready == 4'b0100, "t1_ready_n1", req_ready, 4'b0100);
        step(); step(); #1;
        chk(busy == 1'b1, "t1_busy_n3", busy, 1);
        step(); #1;
        chk(busy == 1'b0, "t1_busy_n4", busy, 0);
        chk(req_ready == '0, "t1_ready_n4", req_ready, 0);
        wait_drain(50);
        chk(txd_log.size() == 3, "t1_count", txd_log.size(), 3);
        for (int j = 0; j < 3 && j < txd_log.size(); j++) begin
            chk(txd_log[j] == 32'hA0 + j, "t1_word", txd_log[j], 32'hA0 + j);
            chk(txc_log[j] == k + 2 + j, "t1_cycle", txc_log[j] - k, 2 + j);
        end

        // 1b: rr_ptr now 3 -> requester 3 before 0
        clear_logs();
        push_burst(0, 1, 32'hB0, 1'b1);
        push_burst(3, 1, 32'hB3, 1'b1);
        build_model();
        drive();
        wait_drain(50);
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
        lit = '{0, 3};
`else
        lit = '{3, 0};
`endif
        cmp_gnt("t1b_order");

        // 2: all four, single-word bursts
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            push_burst(i, 1, 32'hC0 + 16 * i, 1'b1);
            push_burst(i, 1, 32'hC1 + 16 * i, 1'b1);
        end
        build_model();
        drive();
        wait_drain(100);
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
        lit = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
        lit = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif
        cmp_gnt("t2_order");
        for (int j = 0; j + 1 < txc_log.size(); j++)
            chk(txc_log[j + 1] - txc_log[j] == 2, "t2_spacing", txc_log[j + 1] - txc_log[j], 2);

        // 3: requester 1 streams 20 words, burst limit splits it
        clear_logs();
        push_burst(1, 20, 32'h100, 1'b1);
        push_burst(3, 1, 32'h300, 1'b1);
        push_burst(3, 1, 32'h301, 1'b1);
        build_model();
        drive();
        wait_drain(200);
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
        lit = '{1, 1, 1, 3, 3};
`else
        lit = '{1, 3, 1, 3, 1};
`endif
        cmp_gnt("t3_order");
        chk(txd_log.size() == 22, "t3_count", txd_log.size(), 22);
`ifndef CAN_TX_ARB_FIXED_PRIO_EN
        if (txd_log.size() == 22) begin
            chk(txd_log[8] == 32'h300, "t3_after8", txd_log[8], 32'h300);
            chk(txd_log[17] == 32'h301, "t3_after16", txd_log[17], 32'h301);
        end
`endif

        // 4: tx_ready low for 5 cycles mid-burst
        clear_logs();
        push_burst(0, 6, 32'h400, 1'b1);
        build_model();
        k = cyc;
        stall_from = k + 4;
        stall_to   = k + 9;
        drive();
        wait_drain(100);
        stall_from = -1;
        stall_to   = -1;
        chk(txc_log.size() == 6, "t4_count", txc_log.size(), 6);
        if (txc_log.size() == 6) begin
            chk(txc_log[1] == k + 3, "t4_pre", txc_log[1] - k, 3);
            chk(txc_log[2] == k + 9, "t4_resume", txc_log[2] - k, 9);
            chk(txc_log[5] == k + 12, "t4_rate", txc_log[5] - k, 12);
            chk(txd_log[2] == 32'h402, "t4_word2", txd_log[2], 32'h402);
        end

        // 5: reset pulse mid-burst
        clear_logs();
        push_burst(2, 4, 32'h500, 1'b1);
        build_model();
        drive();
        step(); step(); step(); #1;
        chk(tx_valid == 1'b1 && busy == 1'b1, "t5_pre", {tx_valid, busy}, 2'b11);
        chk_en = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        exp_w.delete();
        exp_g.delete();
        m_ptr = 0;
        drive();
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk(tx_valid == 1'b0, "t5_tx_valid", tx_valid, 0);
        chk(busy == 1'b0, "t5_busy", busy, 0);
        chk(grant_id == '0, "t5_grant_id", grant_id, 0);
        step();
        chk_en = 1'b1;
        clear_logs();
        push_burst(0, 1, 32'h600, 1'b1);
        push_burst(3, 1, 32'h603, 1'b1);
        build_model();
        drive();
        wait_drain(50);
        lit = '{0, 3};
        cmp_gnt("t5_rrptr");

        // 6: requesters 0 and 3 both valid
        clear_logs();
        push_burst(0, 1, 32'h700, 1'b1);
        push_burst(0, 1, 32'h701, 1'b1);
        push_burst(0, 1, 32'h702, 1'b1);
        push_burst(3, 1, 32'h703, 1'b1);
        build_model();
        drive();
        wait_drain(100);
`ifdef CAN_TX_ARB_FIXED_PRIO_EN
        lit = '{0, 0, 0, 3};
`else
        lit = '{0, 3, 0, 0};
`endif
        cmp_gnt("t6_order");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
